// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the unit and its divider core.
package muldiv_pkg;

  typedef logic        i1;
  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  function automatic i1 is_mul_op(muldiv_op_t op);
    return !(op == MD_DIV || op == MD_DIVU);
  endfunction

  // Every unsigned variant has an odd opcode.
  function automatic i1 is_signed_op(muldiv_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request and HI/LO write-port bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface muldiv_if;
  import muldiv_pkg::*;

  logic       req_valid;
  logic       req_ready;
  muldiv_op_t req_op;
  i32         req_a;
  i32         req_b;
  i32         hi_in;
  i32         lo_in;
  logic       flush;
  logic       busy;
  logic       done;
  logic       hi_write;
  logic       lo_write;
  i32         hi_data;
  i32         lo_data;

  modport master (
    output req_valid, req_op, req_a, req_b, hi_in, lo_in, flush,
    input  req_ready, busy, done, hi_write, lo_write, hi_data, lo_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, hi_in, lo_in, flush,
    output req_ready, busy, done, hi_write, lo_write, hi_data, lo_data
  );

endinterface

// File: rtl/muldiv_div.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, DIV_ITERS cycles
// after i_start; o_last flags the final iteration cycle.
module muldiv_div
  import muldiv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  i1    i_start,
  input  i1    i_flush,
  input  i32   i_dividend,
  input  i32   i_divisor,
  output i1    o_last,
  output i32   o_quotient,
  output i32   o_remainder
);

  logic [5:0]  r_cnt;
  i32          r_quo;
  i32          r_rem;
  i32          r_dvs;
  logic [32:0] w_shift;
  i1           w_ge;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_cnt <= '0;
      if (reset) begin
        r_quo <= '0;
        r_rem <= '0;
        r_dvs <= '0;
      end
    end else if (i_start) begin
      r_cnt <= 6'(DIV_ITERS);
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 6'd1;
      r_quo <= {r_quo[30:0], w_ge};
      // The true difference is below the divisor, so the 32-bit wrap is exact.
      r_rem <= w_ge ? (w_shift[31:0] - r_dvs) : w_shift[31:0];
    end
  end

  assign o_last      = (r_cnt == 6'd1);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO write port.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {hi_in,lo_in}.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high unless flushed
// MUL   | product in progress, MUL_LAT cycles
// DIV   | divider core iterating, DIV_ITERS cycles
// FIX   | sign correction / divide-by-zero result
// DONE  | result on hi_data/lo_data, write strobes unless flushed
module muldiv
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  muldiv_state_t r_state;
  muldiv_state_t w_next;
  muldiv_op_t    r_op;
  i32            r_a;
  i32            r_b;
  i32            r_hi;
  i32            r_lo;
  logic [1:0]    r_mul_cnt;

  i1  w_accept;
  i1  w_div_start;
  i1  w_div_last;
  i1  w_mul_last;
  i1  w_sgn;
  i32 w_abs_a;
  i32 w_abs_b;
  i32 w_quo;
  i32 w_rem;
  i32 w_fix_hi;
  i32 w_fix_lo;
  i64 w_prod;
  i64 w_mul_res;

  assign bus.req_ready = (r_state == ST_IDLE) & ~bus.flush & ~reset;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_div_start   = w_accept & ~is_mul_op(bus.req_op);
  assign w_mul_last    = (r_mul_cnt == 2'd0);

  assign w_abs_a = (is_signed_op(bus.req_op) && bus.req_a[31]) ? -bus.req_a : bus.req_a;
  assign w_abs_b = (is_signed_op(bus.req_op) && bus.req_b[31]) ? -bus.req_b : bus.req_b;

  muldiv_div u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_flush    (bus.flush),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_last     (w_div_last),
    .o_quotient (w_quo),
    .o_remainder(w_rem)
  );

  assign w_sgn  = is_signed_op(r_op);
  assign w_prod = {{32{w_sgn & r_a[31]}}, r_a} * {{32{w_sgn & r_b[31]}}, r_b};

`ifdef MULDIV_MADD_EN
  i32 r_hi_in;
  i32 r_lo_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi_in <= '0;
      r_lo_in <= '0;
    end else if (w_accept) begin
      r_hi_in <= bus.hi_in;
      r_lo_in <= bus.lo_in;
    end
  end

  always_comb begin
    w_mul_res = w_prod;
    case (r_op)
      MD_MADD, MD_MADDU: w_mul_res = {r_hi_in, r_lo_in} + w_prod;
      MD_MSUB, MD_MSUBU: w_mul_res = {r_hi_in, r_lo_in} - w_prod;
      default:           w_mul_res = w_prod;
    endcase
  end
`else
  wire w_unused_acc = ^{bus.hi_in, bus.lo_in};
  assign w_mul_res = w_prod;
`endif

  always_comb begin
    w_fix_hi = w_rem;
    w_fix_lo = w_quo;
    if (r_b == '0) begin
      w_fix_hi = r_a;
      w_fix_lo = '1;
    end else if (w_sgn) begin
      if (r_a[31] ^ r_b[31]) w_fix_lo = -w_quo;
      if (r_a[31])           w_fix_hi = -w_rem;
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.busy     = (r_state != ST_IDLE);
    bus.done     = 1'b0;
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = is_mul_op(bus.req_op) ? ST_MUL : ST_DIV;
      ST_MUL:  if (bus.flush) w_next = ST_IDLE; else if (w_mul_last) w_next = ST_DONE;
      ST_DIV:  if (bus.flush) w_next = ST_IDLE; else if (w_div_last) w_next = ST_FIX;
      ST_FIX:  w_next = bus.flush ? ST_IDLE : ST_DONE;
      ST_DONE: begin
        w_next       = ST_IDLE;
        bus.done     = 1'b1;
        bus.hi_write = ~bus.flush;
        bus.lo_write = ~bus.flush;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= MD_MULT;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mul_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= bus.req_op;
        r_a       <= bus.req_a;
        r_b       <= bus.req_b;
        r_mul_cnt <= 2'(MUL_LAT - 1);
      end else if (r_state == ST_MUL && !w_mul_last) begin
        r_mul_cnt <= r_mul_cnt - 2'd1;
      end
      // A flushed operation leaves the previous result in place.
      if (r_state == ST_MUL && w_mul_last && !bus.flush) begin
        {r_hi, r_lo} <= w_mul_res;
      end else if (r_state == ST_FIX && !bus.flush) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  assign bus.hi_data = r_hi;
  assign bus.lo_data = r_lo;

endmodule

// File: tb/tb_muldiv.sv
// Randomised and directed bench for muldiv against a plain-arithmetic reference model.
// Honours MULDIV_MADD_EN the same way as the design.
module tb_muldiv;
  import muldiv_pkg::*;

  localparam int MUL_LAT  = 2;
  localparam int MUL_DONE = MUL_LAT + 1;
  localparam int DIV_DONE = DIV_ITERS + 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  muldiv_if bus ();
  muldiv #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hin, lin);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] p, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 3'd2 || op == 3'd3) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == 3'd2) begin
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      uq = ua / ub;
      ur = ua % ub;
      return {ur[31:0], uq[31:0]};
    end
    if (op == 3'd0 || op == 3'd4 || op == 3'd6) p = sa * sb;
    else p = ua * ub;
`ifdef MULDIV_MADD_EN
    if (op == 3'd4 || op == 3'd5) return {hin, lin} + p;
    if (op == 3'd6 || op == 3'd7) return {hin, lin} - p;
`else
    if (hin === 32'hx && lin === 32'hx) return p;
`endif
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, hin, lin, output bit rdy);
    @(negedge clk);
    bus.req_op    = muldiv_op_t'(op);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.hi_in     = hin;
    bus.lo_in     = lin;
    bus.req_valid = 1'b1;
    #1 rdy = bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.hi_in     = $urandom;
    bus.lo_in     = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, hin, lin,
                        output int lat, output logic [31:0] hi, lo,
                        output bit strobes, output bit inflight_ok, output bit rdy);
    issue(op, a, b, hin, lin, rdy);
    lat = -1; hi = '0; lo = '0; strobes = 1'b0; inflight_ok = 1'b1;
    for (int c = 1; c <= DIV_DONE + 6; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c; hi = bus.hi_data; lo = bus.lo_data;
        strobes = bus.hi_write && bus.lo_write;
        break;
      end
      if (!(bus.busy && !bus.req_ready)) inflight_ok = 1'b0;
    end
  endtask

  task automatic test_single_op(input string name, input logic [2:0] op, input logic [31:0] a, b, hin, lin);
    logic [63:0] exp;
    int want_lat, lat;
    logic [31:0] hi, lo;
    bit strobes, inflight_ok, rdy;
    exp = model(op, a, b, hin, lin);
    want_lat = (op == 3'd2 || op == 3'd3) ? DIV_DONE : MUL_DONE;
    run_op(op, a, b, hin, lin, lat, hi, lo, strobes, inflight_ok, rdy);
    vectors += 6;
    if (rdy !== 1'b1) begin miscompares++; $display("FAIL %s ready: got %0b want 1", name, rdy); end
    if (lat !== want_lat) begin miscompares++; $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat); end
    if (inflight_ok !== 1'b1) begin miscompares++; $display("FAIL %s busy/ready in flight: got %0b want 1", name, inflight_ok); end
    if (strobes !== 1'b1) begin miscompares++; $display("FAIL %s strobes: got %0b want 1", name, strobes); end
    if (hi !== exp[63:32]) begin miscompares++; $display("FAIL %s hi op=%0d a=%h b=%h: got %h want %h", name, op, a, b, hi, exp[63:32]); end
    if (lo !== exp[31:0]) begin miscompares++; $display("FAIL %s lo op=%0d a=%h b=%h: got %h want %h", name, op, a, b, lo, exp[31:0]); end
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op = MD_MULT;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors += 5;
    if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset ready: got %b want 0", bus.req_ready); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", bus.done); end
    if ({bus.hi_write, bus.lo_write} !== 2'b00) begin miscompares++; $display("FAIL reset strobes: got %b want 00", {bus.hi_write, bus.lo_write}); end
    if ({bus.hi_data, bus.lo_data} !== 64'd0) begin miscompares++; $display("FAIL reset data: got %h want 0", {bus.hi_data, bus.lo_data}); end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL post-reset ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_directed();
    test_single_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
    test_single_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    test_single_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    test_single_op("divu_zero", 3'd3, 32'd100, 32'd0, 32'd0, 32'd0);
    test_single_op("div_zero", 3'd2, 32'hFFFF_FF00, 32'd0, 32'd0, 32'd0);
    test_single_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    test_single_op("div_pos_neg", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0);
  endtask

  task automatic test_madd();
    test_single_op("maddu", 3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
    test_single_op("madd", 3'd4, 32'hFFFF_FFFF, 32'd5, 32'h1234_5678, 32'h0000_0002);
    test_single_op("msub", 3'd6, 32'hFFFF_FFFD, 32'd4, 32'd0, 32'd0);
    test_single_op("msubu", 3'd7, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1);
  endtask

  task automatic test_flush_div();
    bit rdy, seen;
    issue(3'd2, 32'd1000, 32'd7, 32'd0, 32'd0, rdy);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL flush_div busy c10: got %b want 1", bus.busy); end
    if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL flush_div ready c10: got %b want 0", bus.req_ready); end
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    vectors += 3;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_div busy c11: got %b want 0", bus.busy); end
    if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL flush_div ready c11: got %b want 1", bus.req_ready); end
    if ({bus.hi_data, bus.lo_data} !== {last_hi, last_lo}) begin miscompares++; $display("FAIL flush_div held data: got %h want %h", {bus.hi_data, bus.lo_data}, {last_hi, last_lo}); end
    seen = 1'b0;
    repeat (DIV_DONE + 4) begin
      @(negedge clk);
      if (bus.done || bus.hi_write || bus.lo_write) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_div stray write: got %b want 0", seen); end
  endtask

  task automatic test_flush_done();
    bit rdy;
    logic [63:0] exp;
    exp = model(3'd0, 32'd12345, 32'hFFFF_FF00, 32'd0, 32'd0);
    issue(3'd0, 32'd12345, 32'hFFFF_FF00, 32'd0, 32'd0, rdy);
    repeat (MUL_LAT) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    vectors += 3;
    if (bus.done !== 1'b1) begin miscompares++; $display("FAIL flush_done done: got %b want 1", bus.done); end
    if ({bus.hi_write, bus.lo_write} !== 2'b00) begin miscompares++; $display("FAIL flush_done strobes: got %b want 00", {bus.hi_write, bus.lo_write}); end
    if ({bus.hi_data, bus.lo_data} !== exp) begin miscompares++; $display("FAIL flush_done data: got %h want %h", {bus.hi_data, bus.lo_data}, exp); end
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_done busy after: got %b want 0", bus.busy); end
    bus.req_op = MD_MULT; bus.req_valid = 1'b1; bus.flush = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL flush_idle ready: got %b want 0", bus.req_ready); end
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle accepted: busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_midop();
    bit rdy, seen;
    issue(3'd3, 32'hDEAD_BEEF, 32'd3, 32'd0, 32'd0, rdy);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid busy: got %b want 0", bus.busy); end
    if ({bus.hi_data, bus.lo_data} !== 64'd0) begin miscompares++; $display("FAIL reset_mid data: got %h want 0", {bus.hi_data, bus.lo_data}); end
    seen = 1'b0;
    repeat (DIV_DONE + 4) begin
      @(negedge clk);
      if (bus.done || bus.hi_write) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_mid stray write: got %b want 0", seen); end
    last_hi = '0;
    last_lo = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      test_single_op("random", 3'($urandom_range(0, 7)), pick(), pick(), $urandom, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    test_single_op("b2b_mul", 3'd0, $urandom, $urandom, 32'd0, 32'd0);
    test_single_op("b2b_div", 3'd2, $urandom, pick(), 32'd0, 32'd0);
    test_single_op("b2b_mulu", 3'd1, $urandom, $urandom, 32'd0, 32'd0);
    test_single_op("b2b_divu", 3'd3, $urandom, pick(), 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = MD_MULT;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.hi_in = '0;
    bus.lo_in = '0;
    bus.flush = 1'b0;
    test_reset();
    test_directed();
    test_madd();
    test_flush_div();
    test_flush_done();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
- Multi-cycle multiply/divide unit for the execute stage.
- Accepts one MULT/MULTU/DIV/DIVU (and optionally MADD/MSUB) request, computes for a number of cycles, then drives the HI/LO write port: hi_write, lo_write, hi_data, lo_data.
- The pipeline stalls on busy.
- It is the producing side of the HI/LO register interface.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state before DONE; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept this cycle
- req_op  in  3  muldiv_op_t operation
- req_a  in  32  rs operand / dividend
- req_b  in  32  rt operand / divisor
- hi_in  in  32  current HI, sampled at acceptance (accumulate ops)
- lo_in  in  32  current LO, sampled at acceptance
- flush  in  1  cancel the in-flight operation
- busy  out  1  operation in flight (state != IDLE)
- done  out  1  one-cycle pulse, result valid
- hi_write  out  1  write HI this cycle
- lo_write  out  1  write LO this cycle
- hi_data  out  32  HI result
- lo_data  out  32  LO result

Behaviour:
- Reset values: state IDLE; busy=0, done=0, hi_write=0, lo_write=0, hi_data=0, lo_data=0. req_ready=0 while reset is high. Reset mid-operation discards all work with no write.
- Acceptance: on an edge where req_valid & req_ready. req_ready = (state==IDLE) & ~flush. Operands, op, hi_in and lo_in are registered at that edge (call it cycle 0).
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE -> MUL for mul-class ops; IDLE -> DIV for div-class ops.
- MUL: stay MUL_LAT cycles (down-counter), then DONE. done is seen in cycle MUL_LAT+1 (cycle 3 by default).
- DIV: radix-2 restoring divide on operand magnitudes, one quotient bit per cycle, 32 cycles (6-bit counter).
- DIV -> FIX: sign correction, 1 cycle. FIX -> DONE, so done is seen in cycle 34.
- DONE: done=1, hi_write=lo_write=~flush, result registers drive hi_data/lo_data. DONE -> IDLE unconditionally; a new request can be accepted in the following cycle.
- MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
- DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, sign follows the dividend.
- Division by zero: hi=req_a, lo=32'hFFFF_FFFF for both DIV and DIVU; no exception raised.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- flush: in MUL, DIV or FIX the next state is IDLE with no write. In DONE, writes are suppressed combinationally and done stays 1. flush in IDLE blocks acceptance that cycle.
- hi_data/lo_data hold their last result outside DONE. They are meaningful only when the write strobes are high.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: MADD/MADDU give {hi,lo} = {hi_in,lo_in} + product. MSUB/MSUBU give {hi,lo} = {hi_in,lo_in} - product. Arithmetic is 64-bit wraparound, with signed/unsigned product per op. The accumulate is performed in the last MUL cycle, so latency is unchanged.
- Undefined: MADD* behaves as MULT, MADDU as MULTU, MSUB as MULT, MSUBU as MULTU. hi_in and lo_in are ignored; the ports remain present.

Decomposition:
- Shared defs package adds muldiv_op_t: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MADD=4, MD_MADDU=5, MD_MSUB=6, MD_MSUBU=7.
- Shared defs package adds a muldiv_state_t enum and the constant DIV_ITERS=32.
- Types use the existing i1/i32/i64 aliases.
- One natural sub-module, muldiv_div: an unsigned iterative divider core with start, flush and 32-cycle completion.
- Sign handling and the FSM stay in muldiv.

Test Plan:
- After reset: MULT a=0xFFFFFFFE (-2), b=3 accepted at cycle 0 -> done, hi_write and lo_write high in cycle 3; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy=1 and req_ready=0 in cycles 1-3.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done in cycle 34; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started then flush in cycle 10 -> IDLE in cycle 11, no write strobe, req_ready=1.
- Flush during the DONE cycle -> done=1 with hi_write=lo_write=0.
- With MULDIV_MADD_EN: MADDU with hi_in=0, lo_in=0xFFFFFFFF, a=1, b=1 -> hi=1, lo=0.
- Without MULDIV_MADD_EN: same stimulus -> hi=0, lo=1.
